// File: rtl/pulse_modulator.sv
// ---------------------------------------------------------------------------
// pulse_modulator
//
// Transmit side of the delay-line pulse link. Bytes arrive over a
// valid/ready handshake. Each byte goes out on the line as a frame of
// 10 slots:
//   slot 0     start slot, always carries a pulse
//   slots 1..8 data bits, LSB first ('1' = pulse, '0' = low for the slot)
//   slot 9     guard slot, always low
// A pulse is high for pw_eff cycles at the start of its slot.
//
// Ports
//   clk          in   system clock, everything on posedge
//   reset        in   synchronous active-high reset
//   data_in      in   [7:0] byte to transmit
//   data_valid   in   data_in valid
//   data_ready   out  block accepts a byte this cycle (state == IDLE)
//   pulse_width  in   [PW_BITS-1:0] requested pulse high time, cycles
//   bit_period   in   [BP_BITS-1:0] requested slot length, cycles
//   out          out  modulated line output (registered)
//   busy         out  frame in progress (state != IDLE)
// ---------------------------------------------------------------------------
module pulse_modulator #(
    parameter int PW_BITS = 8,
    parameter int BP_BITS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         data_in,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic [PW_BITS-1:0] pulse_width,
    input  logic [BP_BITS-1:0] bit_period,
    output logic               out,
    output logic               busy
);

    // Common width for clamping arithmetic so neither input is truncated
    // before the min/max comparisons.
    localparam int CW = (PW_BITS > BP_BITS) ? PW_BITS : BP_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLOT  = 2'd1,
        GUARD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [8:0]         shreg_q, shreg_d;   // {data, start bit}, shifted right per slot
    logic [BP_BITS-1:0] ctr_q,   ctr_d;     // cycle within the current slot
    logic [3:0]         idx_q,   idx_d;     // slot index 0..8 while in SLOT
    logic [BP_BITS-1:0] pw_q,    pw_d;      // captured pw_eff
    logic [BP_BITS-1:0] bpl_q,   bpl_d;     // captured bp_eff-1 (terminal count)
    logic               out_q,   out_d;

    // -----------------------------------------------------------------------
    // Effective timing from the live inputs, only used at accept.
    // bp_eff >= 2 and pw_eff <= bp_eff-1 keep at least one low cycle per
    // slot, so consecutive '1' slots remain separable downstream.
    // -----------------------------------------------------------------------
    logic [CW-1:0] bp_ext, pw_ext, bp_eff, bp_last, pw_eff;

    always_comb begin
        bp_ext  = CW'(bit_period);
        pw_ext  = CW'(pulse_width);
        bp_eff  = (bp_ext < CW'(2)) ? CW'(2) : bp_ext;
        bp_last = bp_eff - CW'(1);
        pw_eff  = (pw_ext > bp_last) ? bp_last : pw_ext;
    end

    logic accept;
    assign accept = (state_q == IDLE) && data_valid;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        ctr_d   = ctr_q;
        idx_d   = idx_q;
        pw_d    = pw_q;
        bpl_d   = bpl_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SLOT;
                    shreg_d = {data_in, 1'b1};
                    ctr_d   = '0;
                    idx_d   = 4'd0;
                    pw_d    = pw_eff[BP_BITS-1:0];
                    bpl_d   = bp_last[BP_BITS-1:0];
                end
            end
            SLOT: begin
                if (ctr_q == bpl_q) begin
                    ctr_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (idx_q == 4'd8) begin
                        state_d = GUARD;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    ctr_d = ctr_q + BP_BITS'(1);
                end
            end
            GUARD: begin
                if (ctr_q == bpl_q) begin
                    ctr_d   = '0;
                    state_d = IDLE;
                end else begin
                    ctr_d = ctr_q + BP_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ctr_d   = '0;
                idx_d   = 4'd0;
            end
        endcase

        // The line value is computed from the next-state values so the
        // registered output is high in the very first cycle after accept.
        out_d = (state_d == SLOT) && shreg_d[0] && (ctr_d < pw_d);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            ctr_q   <= '0;
            idx_q   <= 4'd0;
            pw_q    <= '0;
            bpl_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            ctr_q   <= ctr_d;
            idx_q   <= idx_d;
            pw_q    <= pw_d;
            bpl_q   <= bpl_d;
            out_q   <= out_d;
        end
    end

    assign data_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out        = out_q;

endmodule

// File: tb/tb_pulse_modulator.sv
// ---------------------------------------------------------------------------
// tb_pulse_modulator
//
// Stimulus process issues directed bytes; at each accept it pushes the
// hand-computed expected frame (pulse slot mask, effective pulse width and
// slot length, frame length, pulse count) into a scoreboard queue.
// A monitor acting as the downstream demodulator captures the line for the
// duration of each busy window, pops the expected frame and compares the
// waveform, frame length and recovered pulse count.
// ---------------------------------------------------------------------------
module tb_pulse_modulator;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] pulse_width;
    logic [9:0] bit_period;
    logic       line_out;
    logic       busy;

    always #5 clk = ~clk;

    pulse_modulator #(.PW_BITS(8), .BP_BITS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .pulse_width(pulse_width),
        .bit_period (bit_period),
        .out        (line_out),
        .busy       (busy)
    );

    typedef struct {
        logic [8:0] mask;       // slots 0..8 carrying a pulse
        int         pw;         // effective pulse width
        int         bp;         // effective slot length
        int         exp_len;    // busy cycles expected
        int         exp_pulses; // rising edges expected
        int         exp_gap;    // idle cycles before this frame, -1 = don't care
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    function automatic exp_t mk(logic [8:0] mask, int pw, int bp, int len, int pulses, int gap);
        exp_t e;
        e.mask = mask; e.pw = pw; e.bp = bp;
        e.exp_len = len; e.exp_pulses = pulses; e.exp_gap = gap;
        return e;
    endfunction

    function automatic bit exp_bit(exp_t e, int t);
        if (t >= 9 * e.bp) return 1'b0;
        return e.mask[t / e.bp] && ((t % e.bp) < e.pw);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic send(input logic [7:0] d, input int pw, input int bp, input bit hold, input exp_t e);
        int waited;
        data_in     = d;
        pulse_width = pw[7:0];
        bit_period  = bp[9:0];
        data_valid  = 1'b1;
        waited      = 0;
        forever begin
            @(negedge clk);
            if (data_ready === 1'b1) break;
            waited++;
            if (waited > 5000) begin
                $display("FAIL accept_timeout: data_ready stayed low for byte %h", d);
                $fatal(1, "accept timeout");
            end
        end
        @(posedge clk);
        #1;
        sbq.push_back(e);
        if (!hold) data_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        data_valid  = 1'b1;
        data_in     = 8'h55;
        pulse_width = 8'd3;
        bit_period  = 10'd8;
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b0;
        data_valid = 1'b0;

        send(8'hA5, 3, 8, 1'b0, mk(9'h14B, 3, 8, 80, 5, -1));
        send(8'hFF, 20, 8, 1'b0, mk(9'h1FF, 7, 8, 80, 9, -1));   // pw clamped to 7
        send(8'hFF, 20, 1, 1'b0, mk(9'h1FF, 1, 2, 20, 9, -1));   // bp 1 -> 2, pw -> 1
        send(8'hFF, 0, 4, 1'b0, mk(9'h1FF, 0, 4, 40, 0, -1));    // no pulses at all
        // Back-to-back with valid held; second send alters pw/bp mid-frame.
        send(8'h01, 2, 6, 1'b1, mk(9'h003, 2, 6, 60, 2, -1));
        send(8'h80, 5, 10, 1'b0, mk(9'h101, 5, 10, 100, 2, 1));
        // Abort in slot 5 (data bit 4), cycle 2: 43 busy cycles seen.
        send(8'h3C, 3, 8, 1'b0, mk(9'h079, 3, 8, 43, 4, -1));
        repeat (42) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        send(8'h5A, 3, 8, 1'b0, mk(9'h0B5, 3, 8, 80, 5, -1));
        stim_done = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Monitor / demodulator model
    // -----------------------------------------------------------------------
    initial begin
        bit   wave [0:4095];
        int   wlen = 0;
        bit   in_frame = 1'b0;
        bit   unexpected = 1'b0;
        bit   rdy_bad = 1'b0;
        bit   rst_seen = 1'b0;
        int   idle_cnt = 0;
        int   frames_done = 0;
        int   drain = 0;
        exp_t cur;
        cur = mk(9'h000, 0, 2, 0, 0, -1);
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                if (!in_frame) begin
                    in_frame   = 1'b1;
                    wlen       = 0;
                    rdy_bad    = 1'b0;
                    unexpected = 1'b0;
                    if (sbq.size() == 0) begin
                        unexpected = 1'b1;
                        chk("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        cur = sbq.pop_front();
                        if (cur.exp_gap >= 0) chk("b2b_idle_gap", idle_cnt, cur.exp_gap);
                    end
                end
                if (wlen < 4096) wave[wlen] = (line_out === 1'b1);
                wlen++;
                if (data_ready !== 1'b0) rdy_bad = 1'b1;
            end else begin
                if (in_frame) begin
                    int bad_at;
                    int pulses;
                    bit prev;
                    in_frame = 1'b0;
                    idle_cnt = 0;
                    if (!unexpected) begin
                        frames_done++;
                        chk("frame_len", wlen, cur.exp_len);
                        bad_at = -1;
                        pulses = 0;
                        prev   = 1'b0;
                        for (int t = 0; t < wlen && t < 4096; t++) begin
                            if (bad_at < 0 && wave[t] != exp_bit(cur, t)) bad_at = t;
                            if (wave[t] && !prev) pulses++;
                            prev = wave[t];
                        end
                        chk("wave_first_bad_cycle", bad_at, -1);
                        chk("recovered_pulses", pulses, cur.exp_pulses);
                        chk("ready_low_while_busy", rdy_bad, 0);
                    end
                end
                idle_cnt++;
            end

            // Reset sampled at the previous posedge -> idle outputs now.
            if (rst_seen) begin
                chk("reset_out", line_out, 0);
                chk("reset_busy", busy, 0);
                chk("reset_ready", data_ready, 1);
            end
            rst_seen = (reset === 1'b1);

            if (stim_done) begin
                if ((sbq.size() == 0 && !in_frame) || drain > 400) begin
                    chk("scoreboard_left", sbq.size(), 0);
                    chk("frames_seen", frames_done, 8);
                    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                    $finish;
                end
                drain++;
            end
        end
    end

endmodule
